// File: rtl/memoria_de_dados_param.sv
// Byte-lane data memory with registered read, out-of-range flagging and a
// word-per-cycle clear sweep that also runs after every reset.
module memoria_de_dados_param #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 32,
  parameter int LARGURA_END  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     memDadosControle,
  input  logic [LARGURA/8-1:0]     byteEnable,
  input  logic [LARGURA_END-1:0]   enderecoEscrita,
  input  logic [LARGURA-1:0]       dadoEscrita,
  input  logic                     leituraControle,
  input  logic [LARGURA_END-1:0]   enderecoLeitura,
  input  logic                     limpar,
  output logic [LARGURA-1:0]       dadoLeitura,
  output logic                     leituraValida,
  output logic                     erroEndereco,
  output logic                     ocupado
);

  localparam int AW     = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam int EW     = ((LARGURA_END > AW) ? LARGURA_END : AW) + 1;
  localparam int LANES  = LARGURA / 8;

  typedef enum logic {LIMPANDO, PRONTO} estado_t;

  estado_t estado, estadoProx;
  logic [AW-1:0] contador, contadorProx;
  logic [LARGURA-1:0] mem [PROFUNDIDADE];

  logic [EW-1:0] endEscExt, endLeiExt;
  logic [AW-1:0] idxEsc, idxLei;
  logic escritaOk, leituraOk, aceita, escreve, le, erro;

  // Addresses are compared at full width so out-of-range values never alias.
  assign endEscExt = EW'(enderecoEscrita);
  assign endLeiExt = EW'(enderecoLeitura);
  assign idxEsc    = endEscExt[AW-1:0];
  assign idxLei    = endLeiExt[AW-1:0];
  assign escritaOk = endEscExt < EW'(PROFUNDIDADE);
  assign leituraOk = endLeiExt < EW'(PROFUNDIDADE);

  assign aceita  = (estado == PRONTO) && !limpar;
  assign escreve = aceita && memDadosControle && escritaOk;
  assign le      = aceita && leituraControle;
  assign erro    = aceita && ((memDadosControle && !escritaOk) ||
                              (leituraControle && !leituraOk));
  assign ocupado = (estado == LIMPANDO);

  always_comb begin
    estadoProx   = estado;
    contadorProx = contador;
    case (estado)
      LIMPANDO: begin
        if (contador == AW'(PROFUNDIDADE - 1)) begin
          estadoProx   = PRONTO;
          contadorProx = '0;
        end else begin
          contadorProx = contador + 1'b1;
        end
      end
      PRONTO: begin
        if (limpar) begin
          estadoProx   = LIMPANDO;
          contadorProx = '0;
        end
      end
      default: begin
        estadoProx   = LIMPANDO;
        contadorProx = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado        <= LIMPANDO;
      contador      <= '0;
      dadoLeitura   <= '0;
      leituraValida <= 1'b0;
      erroEndereco  <= 1'b0;
    end else begin
      estado        <= estadoProx;
      contador      <= contadorProx;
      leituraValida <= le;
      erroEndereco  <= erro;
      if (le) dadoLeitura <= leituraOk ? mem[idxLei] : '0;
    end
  end

  // Reset forces LIMPANDO asynchronously, which already blocks any pending write.
  always_ff @(posedge clock) begin
    if (estado == LIMPANDO) begin
      mem[contador] <= '0;
    end else if (escreve) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (byteEnable[i]) mem[idxEsc][8*i +: 8] <= dadoEscrita[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/memoria_de_dados_param.md
MEMORIA_DE_DADOS_PARAM -- requirements
Module: memoria_de_dados_param

Interface
REQ-001 The block SHALL provide parameter LARGURA, default 32, data word width in bits (multiple of 8, >= 8).
REQ-002 The block SHALL provide parameter PROFUNDIDADE, default 32, number of words (>= 2).
REQ-003 The block SHALL provide parameter LARGURA_END, default 32, address port width in bits.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  rising-edge system clock.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 memDadosControle  input  1  write request.
REQ-008 byteEnable  input  LARGURA/8  per-byte write lane enable; bit i covers data bits [8i+7:8i].
REQ-009 enderecoEscrita  input  LARGURA_END  write word address.
REQ-010 dadoEscrita  input  LARGURA  write data.
REQ-011 leituraControle  input  1  read request.
REQ-012 enderecoLeitura  input  LARGURA_END  read word address.
REQ-013 limpar  input  1  start a full-memory clear sweep.
REQ-014 dadoLeitura  output  LARGURA  registered read data.
REQ-015 leituraValida  output  1  one-cycle pulse; dadoLeitura updated by a read this cycle.
REQ-016 erroEndereco  output  1  one-cycle pulse; an access in the previous cycle was out of range.
REQ-017 ocupado  output  1  high while the clear sweep runs.

Function
REQ-018 The FSM SHALL have two states: LIMPANDO (sweep) and PRONTO (accepting accesses).
REQ-019 In LIMPANDO, a word counter 0..PROFUNDIDADE-1 SHALL write all-zero to one word per cycle, then go to PRONTO after word PROFUNDIDADE-1 is written; sweep lasts exactly PROFUNDIDADE cycles.
REQ-020 ocupado SHALL equal 1 exactly while in LIMPANDO (Moore output).
REQ-021 In PRONTO, limpar=1 SHALL enter LIMPANDO with counter 0 on the next edge; any write/read requested that cycle SHALL be ignored (limpar wins).
REQ-022 In LIMPANDO, memDadosControle, leituraControle and limpar SHALL be ignored; leituraValida and erroEndereco stay 0.
REQ-023 Write in PRONTO: on a rising edge with memDadosControle=1 and enderecoEscrita < PROFUNDIDADE, only lanes with byteEnable=1 SHALL take dadoEscrita; other lanes keep their value.
REQ-024 Read in PRONTO: leituraControle=1 with enderecoLeitura < PROFUNDIDADE SHALL load the word into dadoLeitura at the next edge (latency 1) and pulse leituraValida for that one cycle.
REQ-025 Read and write to the same address in the same cycle SHALL return the pre-write (old) word (read-first).
REQ-026 Out-of-range (address >= PROFUNDIDADE, full LARGURA_END compare, no wrap) write SHALL leave memory unchanged; out-of-range read SHALL load 0 into dadoLeitura and still pulse leituraValida.
REQ-027 erroEndereco SHALL pulse 1 in the cycle after any out-of-range read or write request in PRONTO (either or both).
REQ-028 dadoLeitura SHALL hold its last value when no read completes, including throughout LIMPANDO.
REQ-029 Write with byteEnable all-zero SHALL not modify memory and SHALL not flag an error if in range.

Reset
REQ-030 reset=0 SHALL immediately force dadoLeitura=0, leituraValida=0, erroEndereco=0, counter=0, state=LIMPANDO (ocupado=1), independent of clock.
REQ-031 After reset release, the block SHALL perform a full sweep (PROFUNDIDADE cycles) before accepting accesses; reset asserted mid-sweep or mid-access SHALL restart from REQ-030, aborting any pending write.

Verification
REQ-032 Reset release, defaults: ocupado=1 for exactly 32 cycles then 0; then reading addresses 0..31 each returns 0x00000000 with leituraValida pulse one cycle after request.
REQ-033 Byte lanes: write 0xAABBCCDD to addr 5 with byteEnable=1111, then 0x11223344 with byteEnable=0101 -> read addr 5 returns 0xAA22CC44.
REQ-034 Collision: addr 7 holds 0x1; same cycle write 0x2 (enable 1111) and read addr 7 -> dadoLeitura=0x1; next read addr 7 -> 0x2.
REQ-035 Range: write 0xDEADBEEF to addr 32 -> erroEndereco pulses one cycle, memory unchanged; read addr 32 -> dadoLeitura=0, leituraValida=1, erroEndereco=1.
REQ-036 Clear: fill addr 3 with 0x55, pulse limpar with a simultaneous write to addr 4 -> ocupado=1 for 32 cycles, read/write requests during sweep ignored, afterwards addr 3 and addr 4 read 0.
REQ-037 Reset mid-sweep: assert reset at sweep cycle 10 for one cycle -> outputs zero asynchronously, new sweep lasts full 32 cycles after release.
